host_rx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that merges four host-side receive FIFOs (9-bit words, bit 8 = frame delimiter) into the single 9-bit stream consumed by the host receive timestamping stage. Never interleaves packets. Drops or terminates malformed packets so that every downstream frame is well-formed. Honours downstream back-pressure and per-port enables from the configuration path.

---
 rtl/host_rx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_host_rx_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_rx_arbiter.sv
// host_rx_arbiter: packet-granular round-robin merge of four show-ahead rx FIFOs
// into one 9-bit stream, dropping or terminating malformed packets.
module host_rx_arbiter #(
    parameter int GAP_CYCLES    = 2,
    parameter int MAX_PKT_WORDS = 1600
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [3:0]  iv_port_en,
    input  logic [35:0] iv_data,
    input  logic [3:0]  i_data_empty,
    output logic [3:0]  o_data_rd,
    input  logic        i_stall,
    output logic [8:0]  ov_data,
    output logic        o_data_wr,
    output logic [1:0]  ov_grant,
    output logic [2:0]  report_arb_state,
    output logic        o_underflow_pulse,
    output logic        o_overlen_pulse,
    output logic        o_misalign_pulse
);
    typedef enum logic [2:0] {IDLE = 3'd0, GAP = 3'd1, HEAD = 3'd2, TRANS = 3'd3, DISC = 3'd4} state_t;

    localparam logic [10:0] LP_MAX      = 11'(MAX_PKT_WORDS);
    localparam logic [1:0]  LP_GAP_LAST = 2'(GAP_CYCLES - 1);
    localparam logic [8:0]  LP_TERM     = 9'h100;

    state_t      r_state, w_next;
    logic [1:0]  r_rr_ptr, w_rr_next, w_pick, r_grant, w_grant_next, r_gap, w_gap_next;
    logic [10:0] r_len, w_len_next;
    logic [8:0]  r_data, w_data_next, w_head;
    logic [8:0]  w_words [4];
    logic [3:0]  w_elig;
    logic        r_wr, w_wr, r_uf, w_uf, r_ol, w_ol, r_ma, w_ma, w_pop, w_empty;

    for (genvar g = 0; g < 4; g++) begin : g_word
        assign w_words[g] = iv_data[9*g +: 9];
    end

    assign w_elig  = iv_port_en & ~i_data_empty;
    assign w_head  = w_words[r_grant];
    assign w_empty = i_data_empty[r_grant];

    // Lowest offset from rr_ptr wins, so scan from the far end inward.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int k = 3; k >= 0; k--)
            if (w_elig[r_rr_ptr + 2'(k)]) w_pick = r_rr_ptr + 2'(k);
    end

    always_comb begin
        w_next       = r_state;
        w_rr_next    = r_rr_ptr;
        w_grant_next = r_grant;
        w_gap_next   = r_gap;
        w_len_next   = r_len;
        w_data_next  = r_data;
        w_wr         = 1'b0;
        w_uf         = 1'b0;
        w_ol         = 1'b0;
        w_ma         = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: if (!i_stall && |w_elig) begin
                w_grant_next = w_pick;
                w_gap_next   = 2'd0;
                w_next       = GAP;
            end
            GAP: begin
                w_gap_next = r_gap + 2'd1;
                w_next     = (r_gap == LP_GAP_LAST) ? HEAD : GAP;
            end
            HEAD: if (w_empty) begin
                w_next = IDLE;
            end else if (!i_stall) begin
                w_pop = 1'b1;
                if (w_head[8]) begin
                    w_data_next = w_head;
                    w_wr        = 1'b1;
                    w_len_next  = 11'd1;
                    w_next      = TRANS;
                end else begin
                    w_ma   = 1'b1;
                    w_next = DISC;
                end
            end
            TRANS: if (!i_stall) begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_wr        = 1'b1;
                    w_len_next  = r_len + 11'd1;
                    w_data_next = w_head;
                    if (w_head[8]) begin
                        w_rr_next = r_grant + 2'd1;
                        w_next    = IDLE;
                    end else if (r_len + 11'd1 == LP_MAX) begin
                        w_data_next = LP_TERM;
                        w_ol        = 1'b1;
                        w_next      = DISC;
                    end
                end else begin
                    // Close the frame early so the downstream parser never sees a dangling packet.
                    w_wr        = 1'b1;
                    w_data_next = LP_TERM;
                    w_uf        = 1'b1;
                    w_next      = DISC;
                end
            end
            DISC: if (!w_empty) begin
                w_pop = 1'b1;
                if (w_head[8]) begin
                    w_rr_next = r_grant + 2'd1;
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next       = IDLE;
                w_data_next  = 9'd0;
                w_grant_next = 2'd0;
                w_rr_next    = 2'd0;
                w_len_next   = 11'd0;
                w_gap_next   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= 2'd0;
            r_grant  <= 2'd0;
            r_gap    <= 2'd0;
            r_len    <= 11'd0;
            r_data   <= 9'd0;
            r_wr     <= 1'b0;
            r_uf     <= 1'b0;
            r_ol     <= 1'b0;
            r_ma     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rr_ptr <= w_rr_next;
            r_grant  <= w_grant_next;
            r_gap    <= w_gap_next;
            r_len    <= w_len_next;
            r_data   <= w_data_next;
            r_wr     <= w_wr;
            r_uf     <= w_uf;
            r_ol     <= w_ol;
            r_ma     <= w_ma;
        end
    end

    assign o_data_rd         = {4{w_pop & ~reset}} & (4'b0001 << r_grant);
    assign ov_data           = r_data;
    assign o_data_wr         = r_wr;
    assign ov_grant          = r_grant;
    assign report_arb_state  = r_state;
    assign o_underflow_pulse = r_uf;
    assign o_overlen_pulse   = r_ol;
    assign o_misalign_pulse  = r_ma;
endmodule

// File: tb/tb_host_rx_arbiter.sv
// tb_host_rx_arbiter: directed checks of host_rx_arbiter with show-ahead FIFO models;
// instance 1 uses a short packet limit for the overlength case.
module tb_host_rx_arbiter;
    localparam int GAP = 2;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic [3:0] en = 4'hF;

    logic [35:0] ivd [2];
    logic [3:0]  emp [2];
    logic [3:0]  rdv [2];
    logic [8:0]  dat [2];
    logic        wrv [2];
    logic [1:0]  gnt [2];
    logic [2:0]  st  [2];
    logic        uf  [2];
    logic        ol  [2];
    logic        ma  [2];

    logic [8:0] mem [2][4][256];
    int rd [2][4];
    int wr [2][4];

    logic [8:0] cap  [2][512];
    logic [1:0] capg [2][512];
    int capc [2][512];
    int on [2], ufn [2], oln [2], man [2];
    int cyc, bad_rd;
    int pass_n, tot_n;

    always #5 clk_sys = ~clk_sys;

    host_rx_arbiter #(.GAP_CYCLES(GAP), .MAX_PKT_WORDS(1600)) dut0 (
        .clk_sys(clk_sys), .reset(reset), .iv_port_en(en), .iv_data(ivd[0]),
        .i_data_empty(emp[0]), .o_data_rd(rdv[0]), .i_stall(stall), .ov_data(dat[0]),
        .o_data_wr(wrv[0]), .ov_grant(gnt[0]), .report_arb_state(st[0]),
        .o_underflow_pulse(uf[0]), .o_overlen_pulse(ol[0]), .o_misalign_pulse(ma[0]));

    host_rx_arbiter #(.GAP_CYCLES(GAP), .MAX_PKT_WORDS(8)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .iv_port_en(en), .iv_data(ivd[1]),
        .i_data_empty(emp[1]), .o_data_rd(rdv[1]), .i_stall(stall), .ov_data(dat[1]),
        .o_data_wr(wrv[1]), .ov_grant(gnt[1]), .report_arb_state(st[1]),
        .o_underflow_pulse(uf[1]), .o_overlen_pulse(ol[1]), .o_misalign_pulse(ma[1]));

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            ivd[d] = '0;
            emp[d] = '0;
            for (int i = 0; i < 4; i++) begin
                ivd[d][9*i +: 9] = mem[d][i][rd[d][i] % 256];
                emp[d][i] = (rd[d][i] == wr[d][i]);
            end
        end
    end

    always @(posedge clk_sys)
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                if (rdv[d][i] && rd[d][i] != wr[d][i]) rd[d][i] <= rd[d][i] + 1;

    always @(negedge clk_sys) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (wrv[d] && on[d] < 512) begin
                cap[d][on[d]]  = dat[d];
                capg[d][on[d]] = gnt[d];
                capc[d][on[d]] = cyc;
                on[d]++;
            end
            ufn[d] += int'(uf[d]);
            oln[d] += int'(ol[d]);
            man[d] += int'(ma[d]);
            if ((rdv[d] & ~(4'b0001 << gnt[d])) != 4'b0) bad_rd++;
        end
    end

    function automatic logic [8:0] pw(input int p, input int k, input int j);
        return (j == 0) ? {1'b1, 8'(8'h40 + p*16 + k)} :
               (j == 1) ? {1'b0, 8'(8'h80 + p*16 + k)} : {1'b1, 8'(8'hC0 + p*16 + k)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic push(input int d, input int p, input logic [8:0] w);
        mem[d][p][wr[d][p] % 256] = w;
        wr[d][p] = wr[d][p] + 1;
    endtask

    task automatic wait_words(input int d, input int target, input int lim, output bit ok);
        ok = (on[d] >= target);
        for (int k = 0; k < lim && !ok; k++) begin
            step(1);
            ok = (on[d] >= target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        tot_n++;
        if ({dat[0], wrv[0], gnt[0], st[0], rdv[0]} !== 19'd0) $display("FAIL reset_outputs: got %h want 0", {dat[0], wrv[0], gnt[0], st[0], rdv[0]});
        else pass_n++;
        tot_n++;
        if ({uf[0], ol[0], ma[0]} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {uf[0], ol[0], ma[0]});
        else pass_n++;
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_single();
        logic [8:0] ex [5];
        int s, c0;
        bit ok;
        ex = '{9'h1AA, 9'h011, 9'h022, 9'h033, 9'h1BB};
        s = on[0];
        for (int i = 0; i < 5; i++) push(0, 0, ex[i]);
        c0 = cyc;
        wait_words(0, s + 5, 40, ok);
        tot_n++;
        if (!ok) $display("FAIL single_timeout: got %0d words want 5", on[0] - s);
        else pass_n++;
        tot_n++;
        if (capc[0][s] - c0 !== 2 + GAP) $display("FAIL single_latency: got %0d want %0d", capc[0][s] - c0, 2 + GAP);
        else pass_n++;
        tot_n++;
        if (capc[0][s+4] - capc[0][s] !== 4) $display("FAIL single_consecutive: got %0d want 4", capc[0][s+4] - capc[0][s]);
        else pass_n++;
        for (int i = 0; i < 5; i++) begin
            tot_n++;
            if (cap[0][s+i] !== ex[i]) $display("FAIL single_word%0d: got %h want %h", i, cap[0][s+i], ex[i]);
            else pass_n++;
        end
        tot_n++;
        if (capg[0][s] !== 2'd0) $display("FAIL single_grant: got %0d want 0", capg[0][s]);
        else pass_n++;
        step(5);
    endtask

    task automatic test_fairness();
        int s, p, k;
        bit ok;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        s = on[0];
        for (int kk = 0; kk < 3; kk++)
            for (int j = 0; j < 3; j++) begin
                push(0, 0, pw(0, kk, j));
                push(0, 2, pw(2, kk, j));
            end
        wait_words(0, s + 18, 200, ok);
        tot_n++;
        if (!ok) $display("FAIL fair_timeout: got %0d words want 18", on[0] - s);
        else pass_n++;
        for (int n = 0; n < 6; n++) begin
            p = (n % 2) * 2;
            k = n / 2;
            tot_n++;
            if (capg[0][s+3*n] !== 2'(p)) $display("FAIL fair_grant%0d: got %0d want %0d", n, capg[0][s+3*n], p);
            else pass_n++;
            for (int j = 0; j < 3; j++) begin
                tot_n++;
                if (cap[0][s+3*n+j] !== pw(p, k, j)) $display("FAIL fair_word%0d_%0d: got %h want %h", n, j, cap[0][s+3*n+j], pw(p, k, j));
                else pass_n++;
            end
        end
        step(5);
    endtask

    task automatic test_back_pressure();
        logic [8:0] ex [10];
        int s;
        bit ok;
        s = on[0];
        for (int i = 0; i < 10; i++) begin
            ex[i] = (i == 0) ? 9'h130 : (i == 9) ? 9'h139 : 9'(9'h030 + i);
            push(0, 3, ex[i]);
        end
        wait_words(0, s + 3, 40, ok);
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1);
            tot_n++;
            if (rdv[0] !== 4'b0 || wrv[0] !== 1'b0) $display("FAIL stall_cycle%0d: got rd=%b wr=%b want rd=0000 wr=0", c, rdv[0], wrv[0]);
            else pass_n++;
        end
        stall = 1'b0;
        wait_words(0, s + 10, 40, ok);
        step(10);
        tot_n++;
        if (on[0] - s !== 10) $display("FAIL stall_count: got %0d want 10", on[0] - s);
        else pass_n++;
        for (int i = 0; i < 10; i++) begin
            tot_n++;
            if (cap[0][s+i] !== ex[i]) $display("FAIL stall_word%0d: got %h want %h", i, cap[0][s+i], ex[i]);
            else pass_n++;
        end
    endtask

    task automatic test_underflow();
        logic [8:0] ex [6];
        int s, u;
        bit ok;
        ex = '{9'h1AA, 9'h055, 9'h100, 9'h1DD, 9'h0EE, 9'h1FF};
        s = on[0];
        u = ufn[0];
        push(0, 1, 9'h1AA);
        push(0, 1, 9'h055);
        wait_words(0, s + 3, 40, ok);
        step(5);
        tot_n++;
        if (ufn[0] - u !== 1) $display("FAIL underflow_pulse: got %0d want 1", ufn[0] - u);
        else pass_n++;
        push(0, 1, 9'h066);
        push(0, 1, 9'h1CC);
        push(0, 1, 9'h1DD);
        push(0, 1, 9'h0EE);
        push(0, 1, 9'h1FF);
        wait_words(0, s + 6, 60, ok);
        step(10);
        tot_n++;
        if (on[0] - s !== 6) $display("FAIL underflow_count: got %0d want 6", on[0] - s);
        else pass_n++;
        for (int i = 0; i < 6; i++) begin
            tot_n++;
            if (cap[0][s+i] !== ex[i]) $display("FAIL underflow_word%0d: got %h want %h", i, cap[0][s+i], ex[i]);
            else pass_n++;
        end
        tot_n++;
        if (emp[0][1] !== 1'b1) $display("FAIL underflow_drain: got empty=%b want 1", emp[0][1]);
        else pass_n++;
    endtask

    task automatic test_overlen_misalign();
        int s, o, m;
        bit ok;
        s = on[1];
        o = oln[1];
        push(1, 0, 9'h140);
        for (int i = 1; i < 19; i++) push(1, 0, 9'(9'h040 + i));
        push(1, 0, 9'h153);
        wait_words(1, s + 8, 60, ok);
        step(30);
        tot_n++;
        if (on[1] - s !== 8) $display("FAIL overlen_count: got %0d want 8", on[1] - s);
        else pass_n++;
        for (int i = 0; i < 8; i++) begin
            tot_n++;
            if (cap[1][s+i] !== ((i == 0) ? 9'h140 : (i == 7) ? 9'h100 : 9'(9'h040 + i)))
                $display("FAIL overlen_word%0d: got %h want %h", i, cap[1][s+i], (i == 0) ? 9'h140 : (i == 7) ? 9'h100 : 9'(9'h040 + i));
            else pass_n++;
        end
        tot_n++;
        if (oln[1] - o !== 1 || emp[1][0] !== 1'b1) $display("FAIL overlen_pulse_drain: got pulses=%0d empty=%b want 1 1", oln[1] - o, emp[1][0]);
        else pass_n++;
        s = on[0];
        m = man[0];
        push(0, 0, 9'h077);
        push(0, 0, 9'h1EE);
        step(20);
        tot_n++;
        if (man[0] - m !== 1) $display("FAIL misalign_pulse: got %0d want 1", man[0] - m);
        else pass_n++;
        tot_n++;
        if (on[0] - s !== 0 || emp[0][0] !== 1'b1) $display("FAIL misalign_nowrite: got writes=%0d empty=%b want 0 1", on[0] - s, emp[0][0]);
        else pass_n++;
    endtask

    task automatic test_enable_mask();
        int s;
        bit ok;
        en = 4'b0100;
        s = on[0];
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 3; j++) push(0, p, pw(p, 5, j));
        wait_words(0, s + 3, 40, ok);
        step(30);
        tot_n++;
        if (on[0] - s !== 3) $display("FAIL enmask_count: got %0d want 3", on[0] - s);
        else pass_n++;
        for (int j = 0; j < 3; j++) begin
            tot_n++;
            if (cap[0][s+j] !== pw(2, 5, j) || capg[0][s+j] !== 2'd2) $display("FAIL enmask_word%0d: got %h/g%0d want %h/g2", j, cap[0][s+j], capg[0][s+j], pw(2, 5, j));
            else pass_n++;
        end
        for (int p = 0; p < 4; p++) wr[0][p] = rd[0][p];
        en = 4'hF;
        step(2);
    endtask

    task automatic test_reset_mid();
        int s, m;
        bit ok;
        s = on[0];
        push(0, 1, 9'h1A0);
        for (int i = 1; i < 9; i++) push(0, 1, 9'(9'h0A0 + i));
        push(0, 1, 9'h1A9);
        wait_words(0, s + 2, 40, ok);
        tot_n++;
        if (st[0] !== 3'd3 || gnt[0] !== 2'd1) $display("FAIL midreset_pre: got state=%0d grant=%0d want 3 1", st[0], gnt[0]);
        else pass_n++;
        reset = 1'b1;
        step(1);
        tot_n++;
        if ({dat[0], wrv[0], gnt[0], st[0], rdv[0]} !== 19'd0) $display("FAIL midreset_outputs: got %h want 0", {dat[0], wrv[0], gnt[0], st[0], rdv[0]});
        else pass_n++;
        reset = 1'b0;
        m = man[0];
        step(40);
        tot_n++;
        if (man[0] - m !== 1 || on[0] - s !== 2) $display("FAIL midreset_residue: got misalign=%0d writes=%0d want 1 2", man[0] - m, on[0] - s);
        else pass_n++;
        tot_n++;
        if (emp[0][1] !== 1'b1) $display("FAIL midreset_drain: got empty=%b want 1", emp[0][1]);
        else pass_n++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_pressure();
        test_underflow();
        test_overlen_misalign();
        test_enable_mask();
        test_reset_mid();
        tot_n++;
        if (bad_rd !== 0) $display("FAIL rd_onehot: got %0d violations want 0", bad_rd);
        else pass_n++;
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
